// File: rtl/exec_cond_stage.sv
// exec_cond_stage: execute-side stage placed directly after the ALU.
// It holds the committed CNVZ flag register, which feeds the ALU's CNVZI input.
// It checks the ARM condition field against the committed flags. When the S bit
// is set and the condition passes, it commits the ALU flags. The instruction
// result goes into a one-entry valid/ready buffer toward writeback.
// It also counts squashed (condition-failed) instructions.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  handshake from the ALU side (in_ready is combinational)
//   alu_result      ALU result, bus bits wide
//   alu_flags       ALU flags, ordered C,N,V,Z from bit 3 down to bit 0
//   cond, set_flags ARM condition field and S bit of the instruction
//   wr_en_in, rd_in register write enable and destination index
//   flush           kills the buffered entry and blocks acceptance
//   flags_q         committed flags, ordered C,N,V,Z
//   out_*           buffered entry toward writeback, qualified by out_valid
//   squash_cnt      saturating count of accepted instructions whose condition failed
module exec_cond_stage #(
  parameter int unsigned bus      = 4,
  parameter int unsigned CNT_W    = 16,
  parameter logic [3:0]  FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [bus-1:0]   alu_result,
  input  logic [3:0]       alu_flags,
  input  logic [3:0]       cond,
  input  logic             set_flags,
  input  logic             wr_en_in,
  input  logic [3:0]       rd_in,
  input  logic             flush,
  output logic [3:0]       flags_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [bus-1:0]   out_result,
  output logic [3:0]       out_rd,
  output logic             out_wr_en,
  output logic             out_executed,
  output logic [CNT_W-1:0] squash_cnt
);

  logic accept;
  logic pass;
  logic flag_c, flag_n, flag_v, flag_z;

  assign flag_c = flags_q[3];
  assign flag_n = flags_q[2];
  assign flag_v = flags_q[1];
  assign flag_z = flags_q[0];

  // The buffer can take a new entry when it is empty or is draining this cycle.
  assign in_ready = ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Evaluate the ARM condition against the committed flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      4'd0:  pass = flag_z;
      4'd1:  pass = ~flag_z;
      4'd2:  pass = flag_c;
      4'd3:  pass = ~flag_c;
      4'd4:  pass = flag_n;
      4'd5:  pass = ~flag_n;
      4'd6:  pass = flag_v;
      4'd7:  pass = ~flag_v;
      4'd8:  pass = flag_c & ~flag_z;
      4'd9:  pass = ~flag_c | flag_z;
      4'd10: pass = (flag_n == flag_v);
      4'd11: pass = (flag_n != flag_v);
      4'd12: pass = ~flag_z & (flag_n == flag_v);
      4'd13: pass = flag_z | (flag_n != flag_v);
      4'd14: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  // Output buffer, flag register and squash counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q      <= FLAG_RST;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rd       <= '0;
      out_wr_en    <= 1'b0;
      out_executed <= 1'b0;
      squash_cnt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_result   <= alu_result;
      out_rd       <= rd_in;
      out_wr_en    <= wr_en_in & pass;
      out_executed <= pass;
      if (set_flags & pass) begin
        flags_q <= alu_flags;
      end
      // The counter saturates at all-ones instead of wrapping.
      if (~pass && (squash_cnt != {CNT_W{1'b1}})) begin
        squash_cnt <= squash_cnt + CNT_W'(1);
      end
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
